// File: rtl/deadlock_report_ctrl.sv
// Debounces monitor block indications into a sticky deadlock, freezes per-monitor
// block-info at detection, and streams blocked monitors out lowest index first.
module deadlock_report_ctrl #(
    parameter int NUM_MON = 2,
    parameter int INFO_W  = 9,
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = $clog2(TIMEOUT + 1),
    localparam int IDX_W  = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MON-1:0]        mon_block,
    input  logic [NUM_MON*INFO_W-1:0] mon_info,
    input  logic                      progress,
    input  logic                      all_idle,
    input  logic                      clear,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [IDX_W-1:0]          rpt_idx,
    output logic [INFO_W-1:0]         rpt_info,
    output logic                      rpt_last,
    output logic                      deadlock,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ARMED, REPORT, DONE} state_t;

    state_t                          state, state_n;
    logic [CNT_W-1:0]                cnt, cnt_n;
    logic [NUM_MON-1:0]              pend, pend_n;
    logic [NUM_MON-1:0][INFO_W-1:0]  snap_info;
    logic                            deadlock_n;
    logic                            snap_en;
    logic                            stall;
    logic [NUM_MON-1:0]              pend_low;
    logic [IDX_W-1:0]                low_idx;
    logic                            in_report;

    assign stall     = (|mon_block) & ~progress & ~all_idle;
    assign in_report = (state == REPORT);
    assign pend_low  = pend & (~pend + NUM_MON'(1));

    always_comb begin
        low_idx = '0;
        for (int unsigned i = NUM_MON; i > 0; i--) begin
            if (pend[i-1]) low_idx = IDX_W'(i - 1);
        end
    end

    assign rpt_valid = in_report;
    assign rpt_idx   = in_report ? low_idx : '0;
    assign rpt_info  = in_report ? snap_info[low_idx] : '0;
    assign rpt_last  = in_report & ((pend & (pend - NUM_MON'(1))) == '0);
    assign busy      = (state == ARMED) | in_report;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pend_n     = pend;
        deadlock_n = deadlock;
        snap_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (stall) begin
                    if (TIMEOUT == 1) begin
                        snap_en = 1'b1;
                    end else begin
                        state_n = ARMED;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            ARMED: begin
                if (!stall) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    snap_en = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    pend_n = pend & ~pend_low;
                    if (rpt_last) state_n = DONE;
                end
            end
            DONE: ;
            default: state_n = IDLE;
        endcase
        if (snap_en) begin
            pend_n     = mon_block;
            deadlock_n = 1'b1;
            state_n    = REPORT;
            cnt_n      = '0;
        end
        // clear overrides a snapshot or handshake landing on the same edge
        if (clear) begin
            state_n    = IDLE;
            cnt_n      = '0;
            pend_n     = '0;
            deadlock_n = 1'b0;
            snap_en    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= '0;
            deadlock  <= 1'b0;
            snap_info <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend     <= pend_n;
            deadlock <= deadlock_n;
            if (snap_en) snap_info <= mon_info;
        end
    end

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Scoreboarded bench for deadlock_report_ctrl at NUM_MON=2, INFO_W=9, TIMEOUT=16.
module tb_deadlock_report_ctrl;

    logic        clock;
    logic        reset;
    logic [1:0]  mon_block;
    logic [17:0] mon_info;
    logic        progress;
    logic        all_idle;
    logic        clear;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [0:0]  rpt_idx;
    logic [8:0]  rpt_info;
    logic        rpt_last;
    logic        deadlock;
    logic        busy;

    typedef struct packed {
        logic [0:0] idx;
        logic [8:0] info;
        logic       last;
    } entry_t;

    entry_t exp_q[$];
    int total = 0;
    int bad   = 0;

    deadlock_report_ctrl #(.NUM_MON(2), .INFO_W(9), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .mon_block(mon_block), .mon_info(mon_info),
        .progress(progress), .all_idle(all_idle), .clear(clear),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_idx(rpt_idx),
        .rpt_info(rpt_info), .rpt_last(rpt_last), .deadlock(deadlock), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic idx, input logic [8:0] info, input logic last);
        entry_t e;
        e.idx = idx; e.info = info; e.last = last;
        exp_q.push_back(e);
    endtask

    // drive stall for 16 cycles, deadlock must appear exactly after the 16th
    task automatic detect(input logic [1:0] blk, input logic [17:0] info, input string tag);
        mon_block = blk; mon_info = info; progress = 1'b0; all_idle = 1'b0;
        repeat (15) step();
        total++;
        if (deadlock !== 1'b0) begin
            bad++; $display("FAIL %s_early deadlock=%b want=0", tag, deadlock);
        end
        step();
        total++;
        if ({deadlock, rpt_valid, busy} !== 3'b111) begin
            bad++; $display("FAIL %s_detect dl/valid/busy=%b want=111", tag, {deadlock, rpt_valid, busy});
        end
    endtask

    task automatic drain(input string tag);
        entry_t e;
        int n = 0;
        rpt_ready = 1'b1;
        while (exp_q.size() > 0 && n < 16) begin
            if (rpt_valid) begin
                e = exp_q.pop_front();
                total++;
                if ({rpt_idx, rpt_info, rpt_last} !== {e.idx, e.info, e.last}) begin
                    bad++;
                    $display("FAIL %s_entry idx/info/last=%0d/%h/%b want=%0d/%h/%b",
                             tag, rpt_idx, rpt_info, rpt_last, e.idx, e.info, e.last);
                end
            end
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL %s_drain_timeout left=%0d want=0", tag, exp_q.size());
            exp_q.delete();
        end
        rpt_ready = 1'b0;
        total++;
        if ({rpt_valid, busy, deadlock, rpt_idx, rpt_info, rpt_last} !== {3'b001, 11'b0}) begin
            bad++; $display("FAIL %s_done valid/busy/dl=%b%b%b idx=%0d info=%h last=%b want=001 0 0 0",
                            tag, rpt_valid, busy, deadlock, rpt_idx, rpt_info, rpt_last);
        end
    endtask

    task automatic do_clear(input string tag);
        mon_block = 2'b00;
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if ({deadlock, busy, rpt_valid} !== 3'b000) begin
            bad++; $display("FAIL %s_clear dl/busy/valid=%b want=000", tag, {deadlock, busy, rpt_valid});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            mon_block = 2'($urandom); mon_info = 18'($urandom); progress = 1'($urandom);
            all_idle = 1'($urandom); clear = 1'($urandom); rpt_ready = 1'($urandom);
            step();
        end
        total++;
        if ({rpt_valid, rpt_idx, rpt_info, rpt_last, deadlock, busy} !== 14'b0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0",
                            {rpt_valid, rpt_idx, rpt_info, rpt_last, deadlock, busy});
        end
        reset = 1'b0; mon_block = '0; mon_info = '0; progress = 0; all_idle = 0;
        clear = 0; rpt_ready = 0;
        step();
        total++;
        if ({deadlock, busy, rpt_valid} !== 3'b000) begin
            bad++; $display("FAIL reset_idle got=%b want=000", {deadlock, busy, rpt_valid});
        end
    endtask

    task automatic test_basic();
        push(1'b1, 9'h1FB, 1'b1);
        detect(2'b10, {9'h1FB, 9'h055}, "basic");
        drain("basic");
        do_clear("basic");
    endtask

    task automatic test_debounce();
        mon_block = 2'b01; mon_info = {9'h000, 9'h0C3}; progress = 0; all_idle = 0;
        repeat (15) step();
        progress = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL debounce_restart busy=%b want=0", busy);
        end
        push(1'b0, 9'h0C3, 1'b1);
        detect(2'b01, {9'h000, 9'h0C3}, "debounce");
        drain("debounce");
        do_clear("debounce");
        mon_block = 2'b11; all_idle = 1'b1;
        repeat (40) step();
        total++;
        if ({deadlock, busy} !== 2'b00) begin
            bad++; $display("FAIL idle_no_deadlock dl/busy=%b want=00", {deadlock, busy});
        end
        all_idle = 1'b0; mon_block = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        push(1'b0, 9'h133, 1'b0);
        push(1'b1, 9'h0AA, 1'b1);
        rpt_ready = 1'b0;
        detect(2'b11, {9'h0AA, 9'h133}, "b2b");
        mon_block = 2'b00;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rpt_valid, rpt_idx, rpt_info, rpt_last} !== {1'b1, exp_q[0].idx, exp_q[0].info, exp_q[0].last}) begin
                bad++; $display("FAIL b2b_hold cyc=%0d valid/idx/info/last=%b/%0d/%h/%b want=1/0/133/0",
                                i, rpt_valid, rpt_idx, rpt_info, rpt_last);
            end
            step();
        end
        drain("b2b");
        do_clear("b2b");
    endtask

    task automatic test_snapshot();
        push(1'b0, 9'h0B5, 1'b0);
        push(1'b1, 9'h16E, 1'b1);
        mon_block = 2'b01; mon_info = {9'h111, 9'h0F0}; progress = 0; all_idle = 0;
        repeat (15) step();
        mon_block = 2'b11; mon_info = {9'h16E, 9'h0B5};
        step();
        mon_block = 2'b00; mon_info = {9'h1FF, 9'h1FF};
        total++;
        if ({deadlock, rpt_valid} !== 2'b11) begin
            bad++; $display("FAIL snap_detect dl/valid=%b want=11", {deadlock, rpt_valid});
        end
        drain("snap");
        do_clear("snap");
    endtask

    task automatic test_clear_mid(input logic use_reset);
        string tag;
        tag = use_reset ? "rst_mid" : "clr_mid";
        detect(2'b11, {9'h0D1, 9'h1A2}, tag);
        rpt_ready = 1'b1; mon_block = 2'b00;
        if (use_reset) reset = 1'b1; else clear = 1'b1;
        step();
        reset = 1'b0; clear = 1'b0; rpt_ready = 1'b0;
        total++;
        if ({deadlock, busy, rpt_valid} !== 3'b000) begin
            bad++; $display("FAIL %s_abort dl/busy/valid=%b want=000", tag, {deadlock, busy, rpt_valid});
        end
        push(1'b0, 9'h04C, 1'b0);
        push(1'b1, 9'h1E7, 1'b1);
        detect(2'b11, {9'h1E7, 9'h04C}, {tag, "_re"});
        drain({tag, "_re"});
        do_clear(tag);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_debounce();
        test_back_to_back();
        test_snapshot();
        test_clear_mid(1'b0);
        test_clear_mid(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached=1 want=0");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/deadlock_report_ctrl.md
# deadlock_report_ctrl

Simulation-side controller that sits above the per-instance deadlock monitors of the cosim testbench. It qualifies their raw `block` indications against a no-progress timeout, freezes a snapshot of every monitor's block-info vector when a deadlock is declared, and sequences that snapshot out one blocked monitor at a time over a valid/ready report port to the testbench reporter. It replaces ad-hoc single-cycle block detection with a debounced, ordered, back-pressurable report stream.

## Interface
Parameters:
- `NUM_MON`, 2: number of monitors aggregated; must be ≥1.
- `INFO_W`, 9: width of each monitor's block-info vector.
- `TIMEOUT`, 16: consecutive stalled cycles required before a deadlock is declared; must be ≥1.
- Derived localparams: `CNT_W = $clog2(TIMEOUT+1)`; `IDX_W = max(1, $clog2(NUM_MON))`.

Ports:
- `clock`, in, 1: sole clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mon_block`, in, NUM_MON: per-monitor `block` outputs.
- `mon_info`, in, NUM_MON*INFO_W: per-monitor block-info; monitor i occupies bits [i*INFO_W +: INFO_W].
- `progress`, in, 1: high when any channel or instance handshake completed this cycle.
- `all_idle`, in, 1: high when the design under test is idle; a block seen while idle is not a deadlock.
- `clear`, in, 1: returns the controller to watching.
- `rpt_valid`, out, 1: report entry present.
- `rpt_ready`, in, 1: reporter accepts the entry.
- `rpt_idx`, out, IDX_W: monitor index of the current entry.
- `rpt_info`, out, INFO_W: snapshotted block-info of that monitor.
- `rpt_last`, out, 1: current entry is the final one.
- `deadlock`, out, 1: sticky deadlock flag.
- `busy`, out, 1: high in ARMED or REPORT.

## Operation
- `stall = |mon_block & ~progress & ~all_idle`.
- States: IDLE, ARMED, REPORT, DONE. Counter `cnt` (CNT_W bits), pending mask `pend` (NUM_MON bits), snapshot array `snap_info` (NUM_MON × INFO_W).
- IDLE: if `stall`, go to ARMED with `cnt` = 1. When TIMEOUT = 1, go directly to the snapshot action instead.
- ARMED: if `~stall`, go to IDLE with `cnt` = 0. Else, if `cnt == TIMEOUT-1`, take the snapshot action. Otherwise `cnt` increments.
- Snapshot action, all on the same edge:
  - `pend <= mon_block`
  - `snap_info <= mon_info`
  - `deadlock <= 1`
  - state goes to REPORT and `cnt <= 0`.
  - `pend` is never zero on entry, because `stall` implies `|mon_block`.
- REPORT:
  - `rpt_valid` = 1.
  - `rpt_idx` = lowest set bit of `pend`.
  - `rpt_info` = `snap_info[rpt_idx]`.
  - `rpt_last` = `pend` has exactly one bit set.
  - On `rpt_valid & rpt_ready`, clear that bit. If it was the last entry, go to DONE.
  - Inputs are ignored in REPORT; later changes to `mon_block`/`mon_info` do not alter the report.
- DONE: `deadlock` holds 1 and no new detection occurs. `clear` returns to IDLE.
- `clear` takes priority in every state except reset:
  - The next state is IDLE.
  - `cnt`, `pend` and `deadlock` all go to 0.
  - A handshake that coincides with `clear` is discarded.
- `reset` has priority over everything. All state is zeroed and the state becomes IDLE.
- `rpt_valid`, `rpt_idx`, `rpt_info` and `rpt_last` are 0 outside REPORT.
- `busy` = (state == ARMED) | (state == REPORT).

## Timing
- Reset values: `rpt_valid` = 0, `rpt_idx` = 0, `rpt_info` = 0, `rpt_last` = 0, `deadlock` = 0, `busy` = 0.
- Detection latency: with `stall` high on cycles 0..TIMEOUT-1, `deadlock` and `rpt_valid` are high from cycle TIMEOUT. The snapshot holds the inputs sampled in cycle TIMEOUT-1.
- A single cycle of `~stall` anywhere in the window restarts the count from zero.
- Report throughput is one entry per cycle while `rpt_ready` is held high.
- Outputs are driven from registers only: `rpt_*` are decoded from the state, `pend` and `snap_info` registers, with no input-to-output paths.
- While `rpt_valid & ~rpt_ready`, all `rpt_*` outputs stay stable.
- DONE is reached the cycle after the last handshake.
- `clear` takes effect on the next edge: `deadlock` is low the following cycle.

## Test plan
- Reset: assert `reset` for 3 cycles with random inputs → all outputs 0, state IDLE.
- Basic detection (NUM_MON=2, TIMEOUT=16): hold `mon_block` = 2'b10, `mon_info[17:9]` = 9'h1FB, `progress` = 0 for 16 cycles → `deadlock` = 1 in cycle 16. One entry is reported: `rpt_idx` = 1, `rpt_info` = 9'h1FB, `rpt_last` = 1. DONE follows.
- Debounce: stall for 15 cycles, pulse `progress` in cycle 15, then stall 16 more → `deadlock` rises only 16 cycles after the pulse. Repeat with `all_idle` = 1 throughout → no deadlock.
- Back-pressure and order: `mon_block` = 2'b11, hold `rpt_ready` = 0 for 5 cycles, then 1 → `rpt_idx` = 0 is held stable for 5 cycles with `rpt_last` = 0. Then `rpt_idx` = 1 with `rpt_last` = 1, then `rpt_valid` = 0.
- Snapshot isolation: change `mon_info` and drop `mon_block` right after detection → the reported `rpt_info` still equals the cycle-15 values.
- Clear/reset mid-report: assert `clear` during REPORT with `rpt_ready` = 1 → IDLE the next cycle, `deadlock` = 0, handshake discarded. Repeat using `reset` → same result. Re-detection then works normally.
